// File: rtl/pipeline_ctrl_if.sv
// Bundle of loader, instruction-memory, hazard-status and pipeline-control signals
// between the sequencing controller (master) and the core/loader side (slave).
interface pipeline_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              load_start;
    logic              run_start;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              im_WE;
    logic [ADDR_W-1:0] im_ADDR;
    logic [31:0]       im_DATA;
    logic              ex_branch_taken;
    logic              id_halt;
    logic              ext_stall_req;
    logic              pipe_clr;
    logic              pc_ENABLE;
    logic              reg_ifid_exmem_ENABLE;
    logic              reg_ifid_exmem_FLUSH;
    logic              reg_exmem_wb_ENABLE;
    logic              halted;
    logic [2:0]        state;
    logic [31:0]       cycle_cnt;

    modport master (
        input  load_start, run_start, load_valid, load_data, load_last,
        input  ex_branch_taken, id_halt, ext_stall_req,
        output load_ready, im_WE, im_ADDR, im_DATA,
        output pipe_clr, pc_ENABLE, reg_ifid_exmem_ENABLE, reg_ifid_exmem_FLUSH,
        output reg_exmem_wb_ENABLE, halted, state, cycle_cnt
    );

    modport slave (
        output load_start, run_start, load_valid, load_data, load_last,
        output ex_branch_taken, id_halt, ext_stall_req,
        input  load_ready, im_WE, im_ADDR, im_DATA,
        input  pipe_clr, pc_ENABLE, reg_ifid_exmem_ENABLE, reg_ifid_exmem_FLUSH,
        input  reg_exmem_wb_ENABLE, halted, state, cycle_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 3-stage core: program load into IM, then
// run/stall/flush/drain/halt control of the PC and both pipeline registers.
module pipeline_ctrl #(
    parameter int unsigned IM_WORDS     = 256,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    pipeline_ctrl_if.master  bus
);
    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(IM_WORDS - 1);
    localparam logic [DrainW-1:0] LastDrain = DrainW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRun   = 3'd2,
        StDrain = 3'd3,
        StHalt  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [31:0]       cycle_q, cycle_d;
    logic              pipe_clr_q, pipe_clr_d;

    logic run_live;
    logic drain_live;
    logic halt_take;

    // A RUN cycle only executes when it is neither the clear cycle nor frozen.
    assign run_live   = (state_q == StRun) && !pipe_clr_q && !bus.ext_stall_req;
    assign drain_live = (state_q == StDrain) && !bus.ext_stall_req;
    assign halt_take  = run_live && bus.id_halt && !bus.ex_branch_taken;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            drain_q    <= '0;
            cycle_q    <= '0;
            pipe_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            cycle_q    <= cycle_d;
            pipe_clr_q <= pipe_clr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        drain_d    = drain_q;
        cycle_d    = cycle_q;
        pipe_clr_d = 1'b0;

        case (state_q)
            StIdle, StHalt: begin
                if (bus.load_start) begin
                    state_d = StLoad;
                    addr_d  = '0;
                end else if (bus.run_start) begin
                    state_d    = StRun;
                    pipe_clr_d = 1'b1;
                end
            end
            StLoad: begin
                if (bus.load_valid) begin
                    addr_d = addr_q + 1'b1;
                    // Leaving before the counter would wrap keeps addresses in range.
                    if (bus.load_last || (addr_q == LastAddr)) begin
                        state_d = StIdle;
                    end
                end
            end
            StRun: begin
                if (halt_take) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                if (drain_live) begin
                    if (drain_q == LastDrain) begin
                        state_d = StHalt;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_q == StRun) && pipe_clr_q) begin
            cycle_d = '0;
        end else if ((run_live || drain_live) && (cycle_q != 32'hFFFF_FFFF)) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    always_comb begin
        bus.load_ready            = 1'b0;
        bus.im_WE                 = 1'b0;
        bus.im_ADDR               = '0;
        bus.im_DATA               = '0;
        bus.pc_ENABLE             = 1'b0;
        bus.reg_ifid_exmem_ENABLE = 1'b0;
        bus.reg_ifid_exmem_FLUSH  = 1'b0;
        bus.reg_exmem_wb_ENABLE   = 1'b0;
        bus.halted                = 1'b0;

        case (state_q)
            StLoad: begin
                bus.load_ready = 1'b1;
                bus.im_WE      = bus.load_valid;
                bus.im_ADDR    = addr_q;
                bus.im_DATA    = bus.load_data;
            end
            StRun: begin
                if (run_live) begin
                    // Taken branch squashes both the wrong-path fetch and any halt with it.
                    bus.pc_ENABLE             = !halt_take;
                    bus.reg_ifid_exmem_ENABLE = 1'b1;
                    bus.reg_ifid_exmem_FLUSH  = bus.ex_branch_taken || bus.id_halt;
                    bus.reg_exmem_wb_ENABLE   = 1'b1;
                end
            end
            StDrain: begin
                if (drain_live) begin
                    bus.reg_ifid_exmem_ENABLE = 1'b1;
                    bus.reg_ifid_exmem_FLUSH  = 1'b1;
                    bus.reg_exmem_wb_ENABLE   = 1'b1;
                end
            end
            StHalt:  bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.cycle_cnt = cycle_q;
    assign bus.pipe_clr  = pipe_clr_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default instance plus a 4-word IM instance
// for the address-limit case.
module tb_pipeline_ctrl;
    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_fail;
    int   we_cnt;
    int   we4_cnt;
    int   clr_cnt;

    pipeline_ctrl_if #(.ADDR_W(8)) bus ();
    pipeline_ctrl_if #(.ADDR_W(2)) bus4 ();

    pipeline_ctrl #(.IM_WORDS(256), .ADDR_W(8), .DRAIN_CYCLES(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    pipeline_ctrl #(.IM_WORDS(4), .ADDR_W(2), .DRAIN_CYCLES(2)) dut4 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pc, ifid, wb, flush}
    logic [3:0] en;
    assign en = {bus.pc_ENABLE, bus.reg_ifid_exmem_ENABLE, bus.reg_exmem_wb_ENABLE,
                 bus.reg_ifid_exmem_FLUSH};

    always @(negedge CLK) begin
        if (bus.im_WE === 1'b1) we_cnt++;
        if (bus4.im_WE === 1'b1) we4_cnt++;
        if (bus.pipe_clr === 1'b1) clr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; we_cnt = 0; we4_cnt = 0; clr_cnt = 0;
        RESET = 1'b0;
        bus.load_start = 0; bus.run_start = 0; bus.load_valid = 0; bus.load_data = '0;
        bus.load_last = 0; bus.ex_branch_taken = 0; bus.id_halt = 0; bus.ext_stall_req = 0;
        bus4.load_start = 0; bus4.run_start = 0; bus4.load_valid = 0; bus4.load_data = '0;
        bus4.load_last = 0; bus4.ex_branch_taken = 0; bus4.id_halt = 0; bus4.ext_stall_req = 0;
        #8;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pipe_clr", 32'(bus.pipe_clr), 32'd0);
        chk("rst_cycle_cnt", bus.cycle_cnt, 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
        #4 RESET = 1'b1;

        // Gapped 4-word load, then a stray 5th beat.
        step(); bus.load_start = 1;
        step(); bus.load_start = 0;
        for (int i = 0; i < 4; i++) begin
            bus.load_valid = 1; bus.load_data = 32'h11 * (i + 1); bus.load_last = (i == 3);
            #1;
            chk("ld_state", 32'(bus.state), 32'd1);
            chk("ld_ready", 32'(bus.load_ready), 32'd1);
            chk("ld_we", 32'(bus.im_WE), 32'd1);
            chk("ld_addr", 32'(bus.im_ADDR), 32'(i));
            chk("ld_data", bus.im_DATA, 32'h11 * (i + 1));
            step(); bus.load_valid = 0; bus.load_last = 0;
            #1;
            chk("ld_gap_we", 32'(bus.im_WE), 32'd0);
            if (i != 3) step();
        end
        chk("ld_done_state", 32'(bus.state), 32'd0);
        bus.load_valid = 1; bus.load_data = 32'h55;
        #1;
        chk("ld_5th_ready", 32'(bus.load_ready), 32'd0);
        chk("ld_5th_we", 32'(bus.im_WE), 32'd0);
        step(); bus.load_valid = 0;
        chk("ld_we_total", 32'(we_cnt), 32'd4);

        // 4-word IM, six beats with no load_last.
        bus4.load_start = 1;
        step(); bus4.load_start = 0;
        for (int i = 0; i < 6; i++) begin
            bus4.load_valid = 1; bus4.load_data = 32'h100 + i;
            #1;
            chk("lim_we", 32'(bus4.im_WE), (i < 4) ? 32'd1 : 32'd0);
            chk("lim_ready", 32'(bus4.load_ready), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) chk("lim_addr", 32'(bus4.im_ADDR), 32'(i));
            step();
        end
        bus4.load_valid = 0;
        chk("lim_state", 32'(bus4.state), 32'd0);
        chk("lim_we_total", 32'(we4_cnt), 32'd4);

        // Run: one clear cycle, then nine clean cycles.
        bus.run_start = 1;
        step(); bus.run_start = 0;
        #1;
        chk("run_state", 32'(bus.state), 32'd2);
        chk("run_clr", 32'(bus.pipe_clr), 32'd1);
        chk("run_clr_en", 32'(en), 32'd0);
        for (int k = 1; k < 10; k++) begin
            step();
            chk("run_en", 32'(en), 32'b1110);
            chk("run_noclr", 32'(bus.pipe_clr), 32'd0);
            chk("run_cnt", bus.cycle_cnt, 32'(k - 1));
        end
        step();
        chk("run_cnt9", bus.cycle_cnt, 32'd9);
        chk("run_clr_once", 32'(clr_cnt), 32'd1);

        // Stall with a pending branch, then the branch unstalled.
        bus.ext_stall_req = 1; bus.ex_branch_taken = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_en", 32'(en), 32'd0);
            chk("stall_cnt", bus.cycle_cnt, 32'd9);
            step();
        end
        bus.ext_stall_req = 0;
        #1;
        chk("br_en", 32'(en), 32'b1111);
        chk("br_cnt", bus.cycle_cnt, 32'd9);
        step(); bus.id_halt = 1;
        #1;
        chk("br_halt_en", 32'(en), 32'b1111);
        step(); bus.ex_branch_taken = 0;
        #1;
        chk("br_halt_state", 32'(bus.state), 32'd2);
        chk("halt_en", 32'(en), 32'b0111);
        chk("halt_cnt", bus.cycle_cnt, 32'd11);

        // Drain with a 3-cycle stall first; branch/halt stay asserted and are ignored.
        step(); bus.ext_stall_req = 1; bus.ex_branch_taken = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("drs_state", 32'(bus.state), 32'd3);
            chk("drs_en", 32'(en), 32'd0);
            chk("drs_cnt", bus.cycle_cnt, 32'd12);
            step();
        end
        bus.ext_stall_req = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("dr_state", 32'(bus.state), 32'd3);
            chk("dr_en", 32'(en), 32'b0111);
            chk("dr_cnt", bus.cycle_cnt, 32'(12 + k));
            step();
        end
        bus.ex_branch_taken = 0; bus.id_halt = 0;
        #1;
        chk("hlt_state", 32'(bus.state), 32'd4);
        chk("hlt_halted", 32'(bus.halted), 32'd1);
        chk("hlt_en", 32'(en), 32'd0);
        chk("hlt_cnt", bus.cycle_cnt, 32'd14);

        // Restart from HALT; plain halt drains for exactly two cycles.
        bus.run_start = 1;
        step(); bus.run_start = 0;
        #1;
        chk("rr_clr", 32'(bus.pipe_clr), 32'd1);
        step();
        chk("rr_cnt_clear", bus.cycle_cnt, 32'd0);
        bus.id_halt = 1;
        step(); bus.id_halt = 0;
        chk("rr_drain0", 32'(bus.state), 32'd3);
        step();
        chk("rr_drain1", 32'(bus.state), 32'd3);
        step();
        chk("rr_halt", 32'(bus.state), 32'd4);
        chk("rr_halt_cnt", bus.cycle_cnt, 32'd3);

        // Reset in the middle of a load at address 2.
        bus.load_start = 1;
        step(); bus.load_start = 0; bus.load_valid = 1; bus.load_data = 32'hA0;
        step(); bus.load_data = 32'hA1;
        step(); bus.load_data = 32'hA2;
        #1;
        chk("mid_addr", 32'(bus.im_ADDR), 32'd2);
        chk("mid_we", 32'(bus.im_WE), 32'd1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.im_WE), 32'd0);
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        bus.load_valid = 0;
        step(); RESET = 1'b1; bus.load_start = 1;
        step(); bus.load_start = 0; bus.load_valid = 1; bus.load_data = 32'hAA;
        #1;
        chk("reload_state", 32'(bus.state), 32'd1);
        chk("reload_addr", 32'(bus.im_ADDR), 32'd0);
        chk("reload_we", 32'(bus.im_WE), 32'd1);
        step(); bus.load_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
